// File: rtl/vec_mem_seq_if.sv
// -----------------------------------------------------------------------------
// vec_mem_if
// Memory beat bus between the vector memory sequencer and the memory port.
//   mem_addr   master->slave  beat byte address
//   mem_wdata  master->slave  beat write data
//   mem_we     master->slave  write strobe
//   mem_re     master->slave  read strobe
//   mem_ready  slave->master  beat accepted / completed this cycle
//   mem_rdata  slave->master  read data, valid with mem_ready on a read beat
// -----------------------------------------------------------------------------
interface vec_mem_if;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_we;
    logic        mem_re;
    logic        mem_ready;
    logic [31:0] mem_rdata;

    modport master (
        output mem_addr, mem_wdata, mem_we, mem_re,
        input  mem_ready, mem_rdata
    );

    modport slave (
        input  mem_addr, mem_wdata, mem_we, mem_re,
        output mem_ready, mem_rdata
    );
endinterface

// File: rtl/vec_mem_seq.sv
// -----------------------------------------------------------------------------
// vec_mem_seq
// Moves a 5-lane vector between the vector datapath and memory, one 32-bit
// beat per accepted memory cycle, at addresses base + STRIDE*lane.
//
// Optional feature macro: VEC_MEM_SEQ_LOAD_EN
//   defined   -> vector load (op=1) supported, rd_0..rd_4 capture read data
//   undefined -> store only; op ignored, mem_re and rd_0..rd_4 are 0
//
// Ports
//   clk               rising-edge clock
//   reset             synchronous active-low reset
//   start             request pulse, sampled only in IDLE
//   op                0 = store, 1 = load
//   base_addr         byte address of lane 0
//   wd_0..wd_4        lanes to store (snapshotted at start)
//   mem               memory beat bus (vec_mem_if.master)
//   rd_0..rd_4        loaded lanes
//   busy              transfer in progress (STORE/LOAD/DONE)
//   done              one-cycle completion pulse
//
// state | meaning
// ------+-----------------------------------------------
// IDLE  | waiting for start
// STORE | write beat idx, advance on mem_ready
// LOAD  | read beat idx, capture rd[idx] on mem_ready
// DONE  | one-cycle done pulse, back to IDLE
// -----------------------------------------------------------------------------
module vec_mem_seq #(
    parameter int unsigned STRIDE = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          op,
    input  logic [31:0]   base_addr,
    input  logic [31:0]   wd_0,
    input  logic [31:0]   wd_1,
    input  logic [31:0]   wd_2,
    input  logic [31:0]   wd_3,
    input  logic [31:0]   wd_4,
    vec_mem_if.master     mem,
    output logic [31:0]   rd_0,
    output logic [31:0]   rd_1,
    output logic [31:0]   rd_2,
    output logic [31:0]   rd_3,
    output logic [31:0]   rd_4,
    output logic          busy,
    output logic          done
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_STORE = 2'd1,
`ifdef VEC_MEM_SEQ_LOAD_EN
        S_LOAD  = 2'd2,
`endif
        S_DONE  = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [2:0]  idx_q, idx_d;
    logic [31:0] base_q;
    logic [31:0] lane_q [5];
    logic        cap_en;
    logic [31:0] beat_addr;

    // Address arithmetic wraps naturally at 2^32.
    assign beat_addr = base_q + (32'(STRIDE) * 32'(idx_q));

`ifdef VEC_MEM_SEQ_LOAD_EN
    logic [31:0] rd_q [5];
    logic        ld_en;
`else
    logic unused_inputs;
    assign unused_inputs = ^{op, mem.mem_rdata};
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= S_IDLE;
            idx_q   <= 3'd0;
            base_q  <= 32'd0;
            for (int i = 0; i < 5; i++) lane_q[i] <= 32'd0;
`ifdef VEC_MEM_SEQ_LOAD_EN
            for (int i = 0; i < 5; i++) rd_q[i] <= 32'd0;
`endif
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            if (cap_en) begin
                base_q    <= base_addr;
                lane_q[0] <= wd_0;
                lane_q[1] <= wd_1;
                lane_q[2] <= wd_2;
                lane_q[3] <= wd_3;
                lane_q[4] <= wd_4;
            end
`ifdef VEC_MEM_SEQ_LOAD_EN
            if (ld_en) rd_q[idx_q] <= mem.mem_rdata;
`endif
        end
    end

    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        cap_en        = 1'b0;
        busy          = 1'b1;
        done          = 1'b0;
        mem.mem_we    = 1'b0;
        mem.mem_re    = 1'b0;
        mem.mem_addr  = 32'd0;
        mem.mem_wdata = 32'd0;
`ifdef VEC_MEM_SEQ_LOAD_EN
        ld_en         = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    cap_en = 1'b1;
                    idx_d  = 3'd0;
`ifdef VEC_MEM_SEQ_LOAD_EN
                    state_d = op ? S_LOAD : S_STORE;
`else
                    state_d = S_STORE;
`endif
                end
            end
            S_STORE: begin
                mem.mem_we    = 1'b1;
                mem.mem_addr  = beat_addr;
                mem.mem_wdata = lane_q[idx_q];
                if (mem.mem_ready) begin
                    if (idx_q == 3'd4) state_d = S_DONE;
                    else               idx_d   = idx_q + 3'd1;
                end
            end
`ifdef VEC_MEM_SEQ_LOAD_EN
            S_LOAD: begin
                mem.mem_re   = 1'b1;
                mem.mem_addr = beat_addr;
                if (mem.mem_ready) begin
                    ld_en = 1'b1;
                    if (idx_q == 3'd4) state_d = S_DONE;
                    else               idx_d   = idx_q + 3'd1;
                end
            end
`endif
            S_DONE: begin
                done    = 1'b1;
                idx_d   = 3'd0;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                idx_d   = 3'd0;
            end
        endcase
    end

`ifdef VEC_MEM_SEQ_LOAD_EN
    assign rd_0 = rd_q[0];
    assign rd_1 = rd_q[1];
    assign rd_2 = rd_q[2];
    assign rd_3 = rd_q[3];
    assign rd_4 = rd_q[4];
`else
    assign rd_0 = 32'd0;
    assign rd_1 = 32'd0;
    assign rd_2 = 32'd0;
    assign rd_3 = 32'd0;
    assign rd_4 = 32'd0;
`endif

endmodule

// File: tb/tb_vec_mem_seq.sv
// -----------------------------------------------------------------------------
// tb_vec_mem_seq
// Directed bench for vec_mem_seq: table rows give per-cycle inputs and the
// expected bus/status outputs; reset abort and lane readback are hand-written.
// -----------------------------------------------------------------------------
module tb_vec_mem_seq;

`ifdef VEC_MEM_SEQ_LOAD_EN
    localparam bit LOAD_EN = 1'b1;
`else
    localparam bit LOAD_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        op;
    logic [31:0] base_addr;
    logic [31:0] wd_0, wd_1, wd_2, wd_3, wd_4;
    logic [31:0] rd_0, rd_1, rd_2, rd_3, rd_4;
    logic        busy, done;
    logic [31:0] rd_w [5];

    vec_mem_if mif();

    vec_mem_seq #(.STRIDE(4)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .base_addr(base_addr),
        .wd_0(wd_0), .wd_1(wd_1), .wd_2(wd_2), .wd_3(wd_3), .wd_4(wd_4),
        .mem(mif),
        .rd_0(rd_0), .rd_1(rd_1), .rd_2(rd_2), .rd_3(rd_3), .rd_4(rd_4),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // Memory model: word at 0x200+4i holds 0x11*(i+1).
    assign mif.mem_rdata = 32'h11 * (((mif.mem_addr - 32'h200) >> 2) + 32'd1);

    assign rd_w[0] = rd_0;
    assign rd_w[1] = rd_1;
    assign rd_w[2] = rd_2;
    assign rd_w[3] = rd_3;
    assign rd_w[4] = rd_4;

    typedef struct {
        logic        start;
        logic        ready;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        we;
        logic        re;
        logic        busy;
        logic        done;
    } vec_t;

    vec_t tbl [32];
    int checks   = 0;
    int failures = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic vec_t row(input logic s, input logic r, input logic [31:0] a,
                                 input logic [31:0] w, input logic we, input logic re,
                                 input logic b, input logic d);
        vec_t v;
        v.start = s; v.ready = r; v.addr = a; v.wdata = w;
        v.we = we; v.re = re; v.busy = b; v.done = d;
        return v;
    endfunction

    task automatic kick(input logic o, input logic [31:0] b, input logic [31:0] w0);
        @(negedge clk);
        start = 1'b1; op = o; base_addr = b;
        mif.mem_ready = 1'b1;
        wd_0 = w0; wd_1 = w0 + 1; wd_2 = w0 + 2; wd_3 = w0 + 3; wd_4 = w0 + 4;
        @(posedge clk);
        #1;
        start = 1'b0;
        // Scramble inputs so a missing snapshot shows up.
        base_addr = 32'hBAD0_0000;
        wd_0 = ~w0; wd_1 = ~w0; wd_2 = ~w0; wd_3 = ~w0; wd_4 = ~w0;
    endtask

    task automatic run_rows(input int first, input int n);
        for (int i = first; i < first + n; i++) begin
            @(negedge clk);
            chk($sformatf("row%0d addr", i),  mif.mem_addr,  tbl[i].addr);
            chk($sformatf("row%0d wdata", i), mif.mem_wdata, tbl[i].wdata);
            chk($sformatf("row%0d we", i),    32'(mif.mem_we), 32'(tbl[i].we));
            chk($sformatf("row%0d re", i),    32'(mif.mem_re), 32'(tbl[i].re));
            chk($sformatf("row%0d busy", i),  32'(busy), 32'(tbl[i].busy));
            chk($sformatf("row%0d done", i),  32'(done), 32'(tbl[i].done));
            start         = tbl[i].start;
            mif.mem_ready = tbl[i].ready;
        end
    endtask

    task automatic chk_rd(input string nm, input bit loaded);
        for (int i = 0; i < 5; i++)
            chk($sformatf("%s rd_%0d", nm, i), rd_w[i],
                loaded ? 32'h11 * 32'(i + 1) : 32'd0);
    endtask

    initial begin
        // A: plain store, base 0x100, lanes A0..A4 (rows 0-6)
        for (int i = 0; i < 5; i++)
            tbl[i] = row(0, 1, 32'h100 + 32'(4 * i), 32'hA0 + 32'(i), 1, 0, 1, 0);
        tbl[5] = row(0, 1, 0, 0, 0, 0, 1, 1);
        tbl[6] = row(0, 1, 0, 0, 0, 0, 0, 0);
        // B: backpressure on beat 2 for 3 cycles (rows 7-16)
        tbl[7]  = row(0, 1, 32'h400, 32'hB0, 1, 0, 1, 0);
        tbl[8]  = row(0, 1, 32'h404, 32'hB1, 1, 0, 1, 0);
        tbl[9]  = row(0, 0, 32'h408, 32'hB2, 1, 0, 1, 0);
        tbl[10] = row(0, 0, 32'h408, 32'hB2, 1, 0, 1, 0);
        tbl[11] = row(0, 0, 32'h408, 32'hB2, 1, 0, 1, 0);
        tbl[12] = row(0, 1, 32'h408, 32'hB2, 1, 0, 1, 0);
        tbl[13] = row(0, 1, 32'h40C, 32'hB3, 1, 0, 1, 0);
        tbl[14] = row(0, 1, 32'h410, 32'hB4, 1, 0, 1, 0);
        tbl[15] = row(0, 1, 0, 0, 0, 0, 1, 1);
        tbl[16] = row(0, 1, 0, 0, 0, 0, 0, 0);
        // C: address wrap, start pulsed mid-transfer and in DONE (rows 17-24)
        tbl[17] = row(0, 1, 32'hFFFF_FFF8, 32'hC0, 1, 0, 1, 0);
        tbl[18] = row(1, 1, 32'hFFFF_FFFC, 32'hC1, 1, 0, 1, 0);
        tbl[19] = row(0, 1, 32'h0000_0000, 32'hC2, 1, 0, 1, 0);
        tbl[20] = row(0, 1, 32'h0000_0004, 32'hC3, 1, 0, 1, 0);
        tbl[21] = row(0, 1, 32'h0000_0008, 32'hC4, 1, 0, 1, 0);
        tbl[22] = row(1, 1, 0, 0, 0, 0, 1, 1);
        tbl[23] = row(0, 1, 0, 0, 0, 0, 0, 0);
        tbl[24] = row(0, 1, 0, 0, 0, 0, 0, 0);
        // D: op=1 -> load at 0x200 when enabled, otherwise a store at 0x500
        for (int i = 0; i < 5; i++) begin
            if (LOAD_EN) tbl[25 + i] = row(0, 1, 32'h200 + 32'(4 * i), 0, 0, 1, 1, 0);
            else         tbl[25 + i] = row(0, 1, 32'h500 + 32'(4 * i), 32'hD0 + 32'(i), 1, 0, 1, 0);
        end
        tbl[30] = row(0, 1, 0, 0, 0, 0, 1, 1);
        tbl[31] = row(0, 1, 0, 0, 0, 0, 0, 0);

        reset = 1'b0; start = 1'b0; op = 1'b0; base_addr = 32'd0;
        wd_0 = 0; wd_1 = 0; wd_2 = 0; wd_3 = 0; wd_4 = 0;
        mif.mem_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset busy",  32'(busy), 32'd0);
        chk("reset done",  32'(done), 32'd0);
        chk("reset we",    32'(mif.mem_we), 32'd0);
        chk("reset re",    32'(mif.mem_re), 32'd0);
        chk("reset addr",  mif.mem_addr, 32'd0);
        chk("reset wdata", mif.mem_wdata, 32'd0);
        chk_rd("reset", 1'b0);
        reset = 1'b1;

        kick(1'b0, 32'h100, 32'hA0);        run_rows(0, 7);
        kick(1'b0, 32'h400, 32'hB0);        run_rows(7, 10);
        kick(1'b0, 32'hFFFF_FFF8, 32'hC0);  run_rows(17, 8);
        kick(1'b1, LOAD_EN ? 32'h200 : 32'h500, 32'hD0); run_rows(25, 7);
        chk_rd("after op1", LOAD_EN);

        // A store must leave loaded lanes alone.
        kick(1'b0, 32'h100, 32'hA0);        run_rows(0, 7);
        chk_rd("after store", LOAD_EN);

        // Reset in beat 3 aborts; a fresh start begins at beat 0.
        kick(1'b0, 32'h600, 32'hE0);
        repeat (3) @(negedge clk);
        @(negedge clk);
        chk("abort pre addr", mif.mem_addr, 32'h60C);
        reset = 1'b0;
        @(negedge clk);
        chk("abort busy", 32'(busy), 32'd0);
        chk("abort we",   32'(mif.mem_we), 32'd0);
        chk("abort done", 32'(done), 32'd0);
        chk("abort addr", mif.mem_addr, 32'd0);
        chk_rd("abort", 1'b0);
        reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk($sformatf("post-abort done c%0d", i), 32'(done), 32'd0);
            chk($sformatf("post-abort busy c%0d", i), 32'(busy), 32'd0);
        end
        kick(1'b0, 32'h700, 32'hE0);
        @(negedge clk);
        chk("restart addr",  mif.mem_addr, 32'h700);
        chk("restart wdata", mif.mem_wdata, 32'hE0);
        chk("restart we",    32'(mif.mem_we), 32'd1);
        repeat (4) @(negedge clk);
        @(negedge clk);
        chk("restart done", 32'(done), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule

// File: doc/vec_mem_seq.md
VEC_MEM_SEQ -- requirements
Module: vec_mem_seq

Interface
REQ-001 Parameter: STRIDE, default 4, byte distance between consecutive lane addresses.
REQ-002 clk  input  1  rising-edge clock.
REQ-003 reset  input  1  synchronous, active-low reset.
REQ-004 start  input  1  request pulse, sampled only in IDLE.
REQ-005 op  input  1  0 = vector store, 1 = vector load.
REQ-006 base_addr  input  32  byte address of lane 0.
REQ-007 wd_0..wd_4  input  32 each  vector lanes to store, driven from the vector ALU results.
REQ-008 mem_ready  input  1  memory accepts or completes the current beat.
REQ-009 mem_rdata  input  32  memory read data, valid when mem_ready=1 during a load beat.
REQ-010 mem_addr  output  32  beat address.
REQ-011 mem_wdata  output  32  beat write data.
REQ-012 mem_we  output  1  write strobe.
REQ-013 mem_re  output  1  read strobe.
REQ-014 rd_0..rd_4  output  32 each  loaded vector lanes, destined for the vector register file.
REQ-015 busy  output  1  high while a transfer is in progress; used to stall the PC.
REQ-016 done  output  1  single-cycle completion pulse.

Function
REQ-017 The FSM SHALL have exactly four states: IDLE, STORE, LOAD and DONE.
REQ-018 In IDLE with start=1, the block SHALL register base_addr, op and wd_0..wd_4, clear the beat index to 0, and enter STORE (op=0) or LOAD (op=1) on the next edge.
REQ-019 start SHALL be ignored in every state other than IDLE; the lane snapshot SHALL NOT change during a transfer.
REQ-020 In STORE, mem_we=1, mem_addr=base+STRIDE*idx (modulo 2^32, wrap permitted) and mem_wdata=lane[idx].
REQ-021 In LOAD, mem_re=1 and mem_addr=base+STRIDE*idx; on an edge with mem_ready=1, rd_idx SHALL capture mem_rdata.
REQ-022 The beat index SHALL advance only on an edge with mem_ready=1; with mem_ready=0, all outputs SHALL hold stable.
REQ-023 On an edge with mem_ready=1 and idx=4, the FSM SHALL enter DONE; each transfer is exactly 5 accepted beats.
REQ-024 In DONE, done=1 for one cycle, mem_we=mem_re=0, and the FSM SHALL return to IDLE; a start in DONE is ignored.
REQ-025 busy SHALL be 1 in STORE, LOAD and DONE, and 0 in IDLE.
REQ-026 Minimum latency SHALL be 7 cycles from the start edge to done inclusive (1 capture, 5 beats, 1 done).
REQ-027 mem_we and mem_re SHALL never be high together; both SHALL be 0 in IDLE and DONE.
REQ-028 rd_0..rd_4 SHALL hold their values until overwritten by a later load beat; a store SHALL NOT modify them.

Reset
REQ-029 With reset=0 at a rising edge, state=IDLE and idx=0, and all outputs SHALL go to 0 (busy, done, mem_we, mem_re, mem_addr, mem_wdata, rd_0..rd_4), together with all internal registers.
REQ-030 Reset in mid-transfer SHALL abort it; no further strobe is issued after the reset edge, and no done pulse is issued.

Configuration
REQ-031 Macro VEC_MEM_SEQ_LOAD_EN: when defined, the LOAD state and the rd_* capture logic are present, as specified above.
REQ-032 When VEC_MEM_SEQ_LOAD_EN is undefined, op SHALL be ignored and treated as 0, mem_re and rd_0..rd_4 SHALL be constant 0, and the LOAD state SHALL NOT exist.

Verification
REQ-033 Store, mem_ready tied 1: base=0x100, wd_i=0xA0+i -> writes 0x100/0xA0, 0x104/0xA1, 0x108/0xA2, 0x10C/0xA3, 0x110/0xA4 on 5 consecutive cycles; done on the 7th cycle after start.
REQ-034 Load: base=0x200, memory word at 0x200+4i = 0x11*(i+1) -> rd_0..rd_4 = 0x11, 0x22, 0x33, 0x44, 0x55; mem_we stays 0 throughout.
REQ-035 Backpressure: mem_ready=0 for 3 cycles during beat 2 -> mem_addr holds base+8 and mem_wdata holds wd_2; done is delayed by exactly 3 cycles.
REQ-036 Wrap and ignored start: base=0xFFFFFFF8 -> beat addresses 0xFFFFFFF8, 0xFFFFFFFC, 0x0, 0x4, 0x8; start pulsed mid-transfer and in DONE -> no second transfer.
REQ-037 Reset at beat 3 -> the next cycle shows busy=0 and mem_we=0 with no done pulse, and a new start then begins at beat 0.
REQ-038 Build without VEC_MEM_SEQ_LOAD_EN, start with op=1 -> a 5-beat store is performed, and rd_* and mem_re remain 0.
